// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, repeated rep+1 times.
// Define SEQ_TX_GAP_EN to insert one low (valid) gap cycle between repetitions.
module seq_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     start,
  input  logic [WIDTH-1:0]         pat_in,
  input  logic [$clog2(WIDTH):0]   len_in,
  input  logic [CNT_W-1:0]         rep_in,
  output logic                     out,
  output logic                     valid,
  output logic                     busy,
  output logic                     done
);
  localparam int LW = $clog2(WIDTH) + 1;

`ifdef SEQ_TX_GAP_EN
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
`endif

  state_t           state_q;
  logic [WIDTH-1:0] pat_q;
  logic [LW-1:0]    len_q, bit_cnt_q;
  logic [CNT_W-1:0] rep_q, rep_cnt_q;
  logic             out_q, valid_q, busy_q, done_q;

  // Bit selection by shifting keeps index widths independent of WIDTH.
  logic [LW-1:0]    len_cl, bit_nx;
  logic [WIDTH-1:0] sh_cap, sh_nx, sh_top;
  logic             last_bit, last_rep;

  always_comb begin
    len_cl   = (len_in > LW'(WIDTH)) ? LW'(WIDTH) : len_in;
    bit_nx   = bit_cnt_q + 1'b1;
    sh_cap   = pat_in >> (len_cl - 1'b1);
    sh_nx    = pat_q >> (len_q - 1'b1 - bit_nx);
    sh_top   = pat_q >> (len_q - 1'b1);
    last_bit = (bit_cnt_q == len_q - 1'b1);
    last_rep = (rep_cnt_q == rep_q);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      rep_q     <= '0;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      out_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          out_q   <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (start && len_in != '0) begin
            state_q   <= SEND;
            pat_q     <= pat_in;
            len_q     <= len_cl;
            rep_q     <= rep_in;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
            out_q     <= sh_cap[0];
            valid_q   <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        SEND: begin
          if (!last_bit) begin
            bit_cnt_q <= bit_nx;
            out_q     <= sh_nx[0];
          end else if (last_rep) begin
            state_q <= DONE;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            rep_cnt_q <= rep_cnt_q + 1'b1;
            bit_cnt_q <= '0;
`ifdef SEQ_TX_GAP_EN
            state_q   <= GAP;
            out_q     <= 1'b0;
`else
            out_q     <= sh_top[0];
`endif
          end
        end
`ifdef SEQ_TX_GAP_EN
        GAP: begin
          state_q <= SEND;
          out_q   <= sh_top[0];
        end
`endif
        DONE: begin
          // start is not sampled here; a held start launches from the next IDLE cycle.
          state_q <= IDLE;
          out_q   <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

`ifndef SEQ_TX_GAP_EN
  logic unused_sh;
  assign unused_sh = ^sh_top[WIDTH-1:1];
`endif
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed + random bench for seq_pattern_tx, checked against a frame-list reference model.
module tb_seq_pattern_tx;
  logic       clk = 1'b0;
  logic       clr, start;
  logic [7:0] pat_in;
  logic [3:0] len_in;
  logic [3:0] rep_in;
  logic       out, valid, busy, done;
  int         n_chk = 0;
  int         n_fail = 0;

  seq_pattern_tx #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .clr(clr), .start(start), .pat_in(pat_in), .len_in(len_in),
    .rep_in(rep_in), .out(out), .valid(valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".out"}, out, 0);
    chk({tag, ".valid"}, valid, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
  endtask

  // Expected serial stream: rep+1 MSB-first copies of the clamped pattern,
  // optionally separated by single zero gap bits.
  task automatic run_frame(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                           input bit hold, input int poke);
    bit e_out[$];
    int L;
    L = (l > 8) ? 8 : int'(l);
    for (int c = 0; c <= int'(r); c++) begin
      for (int i = L - 1; i >= 0; i--) e_out.push_back(p[i]);
`ifdef SEQ_TX_GAP_EN
      if (c < int'(r)) e_out.push_back(1'b0);
`endif
    end
    pat_in = p; len_in = l; rep_in = r; start = 1'b1;
    tick;
    if (!hold) start = 1'b0;
    for (int k = 0; k < e_out.size(); k++) begin
      chk($sformatf("bit%0d.out", k), out, e_out[k]);
      chk($sformatf("bit%0d.valid", k), valid, 1);
      chk($sformatf("bit%0d.busy", k), busy, 1);
      chk($sformatf("bit%0d.done", k), done, 0);
      if (!hold) begin
        pat_in = 8'($urandom); len_in = 4'($urandom); rep_in = 4'($urandom);
        start  = (k == poke);
      end
      tick;
    end
    chk("done.done", done, 1);
    chk("done.busy", busy, 1);
    chk("done.valid", valid, 0);
    chk("done.out", out, 0);
    tick;
    chk_idle("after_done");
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; pat_in = '0; len_in = '0; rep_in = '0;
    #3;
    chk_idle("reset");
    tick; tick;
    chk_idle("reset_held");
    clr = 1'b0;
    tick;

    // Basic 4-bit frame, then two repetitions.
    run_frame(8'h0B, 4'd4, 4'd0, 1'b0, -1);
    run_frame(8'h0B, 4'd4, 4'd1, 1'b0, -1);

    // len_in=0 ignores start.
    pat_in = 8'hFF; len_in = 4'd0; rep_in = 4'd2; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("len0", {busy, valid, done}, 3'b000);
    end
    start = 1'b0;

    // Length clamp.
    run_frame(8'hA5, 4'd15, 4'd0, 1'b0, -1);
    run_frame(8'h3C, 4'd9, 4'd1, 1'b0, -1);

    // Mid-frame start pulse at bit 2 is neither honoured nor queued.
    run_frame(8'h96, 4'd8, 4'd0, 1'b0, 2);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk_idle("no_requeue");
    end

    // Async clear during bit 3 of a 4-bit frame.
    pat_in = 8'h0B; len_in = 4'd4; rep_in = 4'd0; start = 1'b1;
    tick;
    start = 1'b0;
    chk("clr.b1", out, 1); tick;
    chk("clr.b2", out, 0); tick;
    chk("clr.b3", out, 1);
    #2 clr = 1'b1;
    #1;
    chk_idle("clr_async");
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_idle("clr_hold");
    end
    clr = 1'b0;
    tick;
    chk_idle("clr_release");
    run_frame(8'h0B, 4'd4, 4'd0, 1'b0, -1);

    // Held start: back-to-back frames with period len+2.
    for (int f = 0; f < 3; f++) run_frame(8'h0B, 4'd4, 4'd0, 1'b1, -1);
    start = 1'b0;
    tick;
    chk_idle("hold_end");

    // Maximum repeat count: 16 copies with no wrap.
    run_frame(8'h01, 4'd1, 4'd15, 1'b0, -1);
    run_frame(8'h5A, 4'd2, 4'd15, 1'b0, -1);

    // Random frames.
    for (int n = 0; n < 25; n++) begin
      logic [7:0] p;
      logic [3:0] l, r;
      p = 8'($urandom);
      l = 4'($urandom_range(1, 15));
      r = 4'($urandom_range(0, 3));
      run_frame(p, l, r, 1'b0, -1);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        tick;
        chk_idle("rand_gap");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
